// File: rtl/fht_pkg.sv
// Shared constants and FSM state encoding for the FHT peak detector.
package fht_pkg;

  localparam int W_DEF  = 16;
  localparam int N_COEF = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fht_absval.sv
// Combinational magnitude/sign split of a two's-complement coefficient.
module fht_absval #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] mag_o,
  output logic         neg_o
);

  // The most negative value wraps to 2^(W-1), which is its exact unsigned magnitude.
  assign neg_o = x_i[W-1];
  assign mag_o = neg_o ? ((~x_i) + W'(1)) : x_i;

endmodule

// File: rtl/fht_peak_detect.sv
// Sequential scan of a 16-point FHT result for its largest-magnitude coefficient,
// one coefficient per clock, with threshold detection and a sticky overrun flag.
module fht_peak_detect
  import fht_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_COEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [W-1:0]     In0,
  input  logic [W-1:0]     In1,
  input  logic [W-1:0]     In2,
  input  logic [W-1:0]     In3,
  input  logic [W-1:0]     In4,
  input  logic [W-1:0]     In5,
  input  logic [W-1:0]     In6,
  input  logic [W-1:0]     In7,
  input  logic [W-1:0]     In8,
  input  logic [W-1:0]     In9,
  input  logic [W-1:0]     In10,
  input  logic [W-1:0]     In11,
  input  logic [W-1:0]     In12,
  input  logic [W-1:0]     In13,
  input  logic [W-1:0]     In14,
  input  logic [W-1:0]     In15,
  input  logic [W-1:0]     Threshold,
  output logic             Busy,
  output logic             OutValid,
  output logic [IDX_W-1:0] PeakIdx,
  output logic [W-1:0]     PeakMag,
  output logic             PeakNeg,
  output logic             Detect,
  output logic             Overrun
);

  logic [W-1:0]     in_arr [N];
  logic [W-1:0]     coef_q [N];
  logic [W-1:0]     thr_q;
  state_t           state_q;
  logic [IDX_W-1:0] count_q;
  logic [W-1:0]     max_mag_q;
  logic [IDX_W-1:0] max_idx_q;
  logic             max_neg_q;

  logic [W-1:0]     cur_mag;
  logic             cur_neg;
  logic             take;
  logic [W-1:0]     best_mag_d;
  logic [IDX_W-1:0] best_idx_d;
  logic             best_neg_d;

  always_comb begin
    in_arr[0]  = In0;
    in_arr[1]  = In1;
    in_arr[2]  = In2;
    in_arr[3]  = In3;
    in_arr[4]  = In4;
    in_arr[5]  = In5;
    in_arr[6]  = In6;
    in_arr[7]  = In7;
    in_arr[8]  = In8;
    in_arr[9]  = In9;
    in_arr[10] = In10;
    in_arr[11] = In11;
    in_arr[12] = In12;
    in_arr[13] = In13;
    in_arr[14] = In14;
    in_arr[15] = In15;
  end

  fht_absval #(.W(W)) u_absval (
    .x_i   (coef_q[count_q]),
    .mag_o (cur_mag),
    .neg_o (cur_neg)
  );

  // Strict compare: equal magnitudes keep the earlier (lower) index.
  always_comb begin
    take       = cur_mag > max_mag_q;
    best_mag_d = take ? cur_mag : max_mag_q;
    best_idx_d = take ? count_q : max_idx_q;
    best_neg_d = take ? cur_neg : max_neg_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      coef_q    <= '{default: '0};
      thr_q     <= '0;
      max_mag_q <= '0;
      max_idx_q <= '0;
      max_neg_q <= 1'b0;
      Busy      <= 1'b0;
      OutValid  <= 1'b0;
      PeakIdx   <= '0;
      PeakMag   <= '0;
      PeakNeg   <= 1'b0;
      Detect    <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (InValid) begin
            for (int unsigned i = 0; i < N; i++) coef_q[i] <= in_arr[i];
            thr_q     <= Threshold;
            count_q   <= '0;
            max_mag_q <= '0;
            max_idx_q <= '0;
            max_neg_q <= 1'b0;
            state_q   <= ST_SCAN;
            Busy      <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            Busy    <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (InValid) Overrun <= 1'b1;
          max_mag_q <= best_mag_d;
          max_idx_q <= best_idx_d;
          max_neg_q <= best_neg_d;
          count_q   <= count_q + IDX_W'(1);
          if (count_q == IDX_W'(N - 1)) begin
            PeakIdx  <= best_idx_d;
            PeakMag  <= best_mag_d;
            PeakNeg  <= best_neg_d;
            Detect   <= best_mag_d > thr_q;
            OutValid <= 1'b1;
            state_q  <= ST_DONE;
            Busy     <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fht_peak_detect.sv
// Directed self-checking bench for fht_peak_detect.
module tb_fht_peak_detect;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         InValid;
  logic [W-1:0] vin [16];
  logic [W-1:0] Threshold;
  logic         Busy;
  logic         OutValid;
  logic [3:0]   PeakIdx;
  logic [W-1:0] PeakMag;
  logic         PeakNeg;
  logic         Detect;
  logic         Overrun;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fht_peak_detect #(.W(W), .N(16)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid),
    .In0(vin[0]),   .In1(vin[1]),   .In2(vin[2]),   .In3(vin[3]),
    .In4(vin[4]),   .In5(vin[5]),   .In6(vin[6]),   .In7(vin[7]),
    .In8(vin[8]),   .In9(vin[9]),   .In10(vin[10]), .In11(vin[11]),
    .In12(vin[12]), .In13(vin[13]), .In14(vin[14]), .In15(vin[15]),
    .Threshold(Threshold),
    .Busy(Busy), .OutValid(OutValid), .PeakIdx(PeakIdx), .PeakMag(PeakMag),
    .PeakNeg(PeakNeg), .Detect(Detect), .Overrun(Overrun)
  );

  function automatic logic [21:0] res();
    return {PeakIdx, PeakMag, PeakNeg, Detect};
  endfunction

  task automatic load_vec(input int ia, input int va, input int ib, input int vb, input int thr);
    for (int i = 0; i < 16; i++) vin[i] = '0;
    if (ia >= 0) vin[ia] = W'(va);
    if (ib >= 0) vin[ib] = W'(vb);
    Threshold = W'(thr);
  endtask

  task automatic fire();
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_ov(output int n, output bit got);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge Clk); #1;
      n++;
      if (OutValid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    InValid = 1'b0;
    load_vec(-1, 0, -1, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({Busy, OutValid, PeakIdx, PeakMag, PeakNeg, Detect, Overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {Busy, OutValid, PeakIdx, PeakMag, PeakNeg, Detect, Overrun});
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (Busy !== 1'b0 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ov=%b want 0 0", Busy, OutValid);
    end
  endtask

  task automatic test_basic();
    int n;
    bit got;
    load_vec(5, -300, 9, 299, 100);
    fire();
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", Busy);
    end
    wait_ov(n, got);
    checks++;
    if (!got || n !== 16) begin
      errors++;
      $display("FAIL basic_latency: got %0d (seen=%b) want 16", n, got);
    end
    checks++;
    if (PeakIdx !== 4'd5 || PeakMag !== 16'd300) begin
      errors++;
      $display("FAIL basic_idx_mag: got idx=%0d mag=%0d want idx=5 mag=300", PeakIdx, PeakMag);
    end
    checks++;
    if (PeakNeg !== 1'b1 || Detect !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got neg=%b det=%b busy=%b want 1 1 0", PeakNeg, Detect, Busy);
    end
    @(posedge Clk); #1;
    checks++;
    if (OutValid !== 1'b0 || res() !== {4'd5, 16'd300, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL basic_hold: got ov=%b res=%h want ov=0 res=%h", OutValid, res(),
               {4'd5, 16'd300, 1'b1, 1'b1});
    end
  endtask

  task automatic test_tie();
    int n;
    bit got;
    load_vec(3, 500, 11, 500, 500);
    fire();
    wait_ov(n, got);
    checks++;
    if (!got || n !== 16 || res() !== {4'd3, 16'd500, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tie_thr_equal: got n=%0d res=%h want n=16 res=%h", n, res(),
               {4'd3, 16'd500, 1'b0, 1'b0});
    end
    load_vec(3, 500, 11, 500, 499);
    fire();
    wait_ov(n, got);
    checks++;
    if (!got || res() !== {4'd3, 16'd500, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tie_thr_below: got res=%h want %h", res(), {4'd3, 16'd500, 1'b0, 1'b1});
    end
  endtask

  task automatic test_min_neg();
    int n;
    bit got;
    load_vec(15, -32768, -1, 0, 0);
    fire();
    wait_ov(n, got);
    checks++;
    if (!got || res() !== {4'd15, 16'h8000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL min_neg: got res=%h want %h", res(), {4'd15, 16'h8000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_zero();
    int n;
    bit got;
    load_vec(-1, 0, -1, 0, 0);
    fire();
    wait_ov(n, got);
    checks++;
    if (!got || res() !== 22'd0) begin
      errors++;
      $display("FAIL all_zero: got res=%h want 0", res());
    end
  endtask

  task automatic test_overrun();
    int pulses;
    int first_edge;
    logic [21:0] first_res;
    checks++;
    if (Overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b want 0", Overrun);
    end
    load_vec(5, -300, 9, 299, 100);
    fire();
    repeat (4) @(posedge Clk);
    #1;
    load_vec(0, 1000, -1, 0, 0);
    fire();
    checks++;
    if (Overrun !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%b busy=%b want 1 1", Overrun, Busy);
    end
    pulses = 0;
    first_edge = 0;
    first_res = '0;
    for (int k = 6; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (OutValid) begin
        pulses++;
        if (pulses == 1) begin
          first_edge = k;
          first_res = res();
        end
      end
    end
    checks++;
    if (pulses !== 1 || first_edge !== 16) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d pulses first at %0d want 1 at 16", pulses, first_edge);
    end
    checks++;
    if (first_res !== {4'd5, 16'd300, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overrun_result: got %h want %h", first_res, {4'd5, 16'd300, 1'b1, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    load_vec(5, -300, 9, 299, 100);
    fire();
    wait_ov(n, got);
    load_vec(7, 1234, -1, 0, 2000);
    fire();
    checks++;
    if (Busy !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b ov=%b want 1 0", Busy, OutValid);
    end
    wait_ov(n, got);
    checks++;
    if (!got || n + 1 !== 17) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 17", n + 1);
    end
    checks++;
    if (res() !== {4'd7, 16'd1234, 1'b0, 1'b0} || Overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: got res=%h ovr=%b want res=%h ovr=1", res(), Overrun,
               {4'd7, 16'd1234, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit got;
    int pulses;
    load_vec(5, -300, 9, 299, 100);
    fire();
    repeat (8) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, OutValid, PeakIdx, PeakMag, PeakNeg, Detect, Overrun} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0",
               {Busy, OutValid, PeakIdx, PeakMag, PeakNeg, Detect, Overrun});
    end
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge Clk); #1;
      if (OutValid) pulses++;
    end
    checks++;
    if (pulses !== 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abandon: got %0d pulses busy=%b want 0 0", pulses, Busy);
    end
    load_vec(3, 500, 11, 500, 499);
    fire();
    wait_ov(n, got);
    checks++;
    if (!got || n !== 16 || res() !== {4'd3, 16'd500, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_recover: got n=%0d res=%h want n=16 res=%h", n, res(),
               {4'd3, 16'd500, 1'b0, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_min_neg();
    test_zero();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fht_peak_detect.md
FHT_PEAK_DETECT -- requirements
Module: fht_peak_detect

Interface
REQ-001 SHALL have parameter W, default 16: width of each FHT coefficient input, two's complement.
REQ-002 SHALL have parameter N, default 16, fixed: number of coefficients per transform; index width log2(N)=4.
REQ-003 SHALL have port Clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port InValid, input, 1 bit: one-cycle strobe marking In0..In15 as a complete 4th-stage FHT result.
REQ-006 SHALL have ports In0..In15, input, W bits each: signed FHT coefficients.
REQ-007 SHALL have port Threshold, input, W bits: unsigned detection threshold, sampled with InValid.
REQ-008 SHALL have port Busy, output, 1 bit: high while a scan is in progress.
REQ-009 SHALL have port OutValid, output, 1 bit: one-cycle result strobe.
REQ-010 SHALL have port PeakIdx, output, 4 bits: index of the largest-magnitude coefficient.
REQ-011 SHALL have port PeakMag, output, W bits: unsigned magnitude of that coefficient.
REQ-012 SHALL have port PeakNeg, output, 1 bit: sign of that coefficient (1 = negative).
REQ-013 SHALL have port Detect, output, 1 bit: PeakMag strictly greater than the sampled Threshold.
REQ-014 SHALL have port Overrun, output, 1 bit: sticky flag for a dropped InValid.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 SHALL, in IDLE or DONE with InValid high at edge E0, capture In0..In15 and Threshold, clear the running max, set count=0 and enter SCAN.
REQ-017 SHALL, in SCAN at edges E1..E16, examine coefficient[count] at one coefficient per edge and increment count.
REQ-018 SHALL compute magnitude as |x| in W-bit unsigned form; -2^(W-1) yields 2^(W-1) without saturation.
REQ-019 SHALL replace the running max only when the magnitude is strictly greater; ties keep the lower index.
REQ-020 SHALL, at E16 (count=15), load PeakIdx, PeakMag, PeakNeg and Detect, assert OutValid and enter DONE.
REQ-021 SHALL make the result latency 16 edges after capture and the minimum accept-to-accept interval 17 cycles.
REQ-022 SHALL, in DONE, deassert OutValid at the next edge and enter IDLE, unless InValid is high at that edge, in which case REQ-016 applies (back-to-back).
REQ-023 SHALL ignore InValid while in SCAN, set Overrun and leave the scan undisturbed.
REQ-024 SHALL drive Busy = (state == SCAN).
REQ-025 SHALL hold PeakIdx, PeakMag, PeakNeg and Detect stable until the next OutValid.
REQ-026 SHALL produce PeakIdx=0, PeakMag=0 and PeakNeg=0 when all coefficients are zero.

Reset
REQ-027 SHALL, on Reset low, asynchronously force state IDLE, count 0, Busy 0, OutValid 0, PeakIdx 0, PeakMag 0, PeakNeg 0, Detect 0 and Overrun 0.
REQ-028 SHALL, on reset asserted mid-scan, abandon the scan with no OutValid; first acceptance occurs at the first edge after Reset deasserts.
REQ-029 SHALL clear Overrun only by reset.

Structure
REQ-030 SHALL place the W and N constants and the state encoding in shared package fht_pkg.
REQ-031 SHALL implement the magnitude/sign split in sub-module fht_absval (W in; W-bit magnitude and sign out; combinational).
REQ-032 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-033 SHALL cover: In5=-300, In9=+299, others 0, Threshold=100 -> OutValid 16 edges later, PeakIdx=5, PeakMag=300, PeakNeg=1, Detect=1.
REQ-034 SHALL cover: In3=In11=+500, others 0 -> PeakIdx=3; with Threshold=500 -> Detect=0.
REQ-035 SHALL cover: In15=-32768 -> PeakMag=32768, PeakIdx=15, PeakNeg=1.
REQ-036 SHALL cover: second InValid 5 cycles after the first -> Overrun=1, first result unaffected, exactly one OutValid; InValid during DONE -> second result 17 cycles after the first.
REQ-037 SHALL cover: Reset low at scan edge 8 -> all outputs zero, no OutValid; a new InValid after release -> normal result.
